// File: rtl/VX_gpu_pkg.sv
// Shared GPU pipeline types and constants used by the writeback sequencer.
package VX_gpu_pkg;

    // Warps handled by one issue slice and the width of a warp index within it.
    localparam int unsigned PER_ISSUE_WARPS = 4;
    localparam int unsigned ISSUE_WIS_W     = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;

    // Beat field widths.
    localparam int unsigned UUID_W      = 16;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned NR_BITS     = 5;

    // Default width of each per-warp outstanding-writeback counter.
    localparam int unsigned PEND_BITS_DEFAULT = 4;

    // One writeback beat; sop/eop delimit multi-beat packets from a single unit.
    typedef struct packed {
        logic [UUID_W-1:0]           uuid;
        logic [ISSUE_WIS_W-1:0]      wis;
        logic [NUM_THREADS-1:0]      tmask;
        logic [PC_W-1:0]             PC;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic                        sop;
        logic                        eop;
    } wb_beat_t;

    // Increment an index modulo n.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_wb_lock_arb.sv
// Round-robin arbiter with packet lock: once a unit starts a multi-beat packet,
// only that unit is granted until its eop beat is accepted.
module vx_wb_lock_arb
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] valid_in,
    input  logic [NUM_INPUTS-1:0] sop_in,
    input  logic [NUM_INPUTS-1:0] eop_in,
    output logic [NUM_INPUTS-1:0] grant_out
);

    localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic                  lock_q, lock_d;
    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      gidx;
    logic [IDX_W-1:0]      jj;
    logic                  found;
    logic                  accept;
    int unsigned           j;

    // Pick the granted unit: the locked owner, else first valid at or after the pointer.
    always_comb begin
        grant = '0;
        gidx  = ptr_q;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        if (lock_q) begin
            gidx = lock_idx_q;
            // Owner stalling leaves everyone else waiting rather than breaking the packet.
            grant[lock_idx_q] = valid_in[lock_idx_q];
        end else begin
            for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                j  = (32'(ptr_q) + k) % NUM_INPUTS;
                jj = IDX_W'(j);
                if (!found && valid_in[jj]) begin
                    found     = 1'b1;
                    grant[jj] = 1'b1;
                    gidx      = jj;
                end
            end
        end
    end

    // Nothing is accepted while reset is held.
    assign grant_out = reset ? grant : '0;
    assign accept    = |grant_out;

    // Advance the pointer past a finished packet; set or clear the lock on packet edges.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (eop_in[gidx]) begin
                ptr_d  = IDX_W'(rr_wrap_inc(32'(gidx), NUM_INPUTS));
                lock_d = 1'b0;
            end else if (sop_in[gidx] && !lock_q) begin
                lock_d     = 1'b1;
                lock_idx_d = gidx;
            end
        end
    end

    // Pointer and lock state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/vx_wb_sequencer.sv
// Writeback sequencer: merges execution-unit result beats into one registered
// writeback stream and tracks per-warp outstanding writebacks for drain detection.
module vx_wb_sequencer
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned PEND_BITS  = PEND_BITS_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic     [NUM_INPUTS-1:0]        in_valid,
    input  wb_beat_t [NUM_INPUTS-1:0]        in_data,
    output logic     [NUM_INPUTS-1:0]        in_ready,
    input  logic                             issue_valid,
    input  logic     [ISSUE_WIS_W-1:0]       issue_wis,
    output logic                             wb_valid,
    output wb_beat_t                         wb_data,
    output logic     [PER_ISSUE_WARPS-1:0]   pending_empty,
    output logic     [1:0]                   err_flags
);

    localparam logic [PEND_BITS-1:0] CNT_MAX = '1;

    logic [NUM_INPUTS-1:0] sop_vec;
    logic [NUM_INPUTS-1:0] eop_vec;
    logic [NUM_INPUTS-1:0] grant;
    wb_beat_t              sel_beat;

    logic                  wb_valid_q;
    wb_beat_t              wb_data_q;

    logic [PEND_BITS-1:0]  cnt_q [PER_ISSUE_WARPS];
    logic [PEND_BITS-1:0]  cnt_d [PER_ISSUE_WARPS];
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  inc, dec;

    // Split packet delimiters out of each unit's beat for the arbiter.
    always_comb begin
        sop_vec = '0;
        eop_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sop_vec[i] = in_data[i].sop;
            eop_vec[i] = in_data[i].eop;
        end
    end

    vx_wb_lock_arb #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (in_valid),
        .sop_in    (sop_vec),
        .eop_in    (eop_vec),
        .grant_out (grant)
    );

    assign in_ready = grant;

    // One-hot select of the granted unit's beat.
    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                sel_beat = in_data[i];
            end
        end
    end

    // Output register; data holds across idle cycles, valid pulses per accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= |grant;
            if (|grant) begin
                wb_data_q <= sel_beat;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;

    // Per-warp counter update: issue increments, a visible eop writeback decrements,
    // both on the same warp cancel; saturating ends raise sticky error flags.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int unsigned w = 0; w < PER_ISSUE_WARPS; w++) begin
            cnt_d[w] = cnt_q[w];
            inc = issue_valid && (32'(issue_wis) == w);
            dec = wb_valid_q && wb_data_q.eop && (32'(wb_data_q.wis) == w);
            if (inc && !dec) begin
                if (cnt_q[w] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[w] = cnt_q[w] + PEND_BITS'(1);
                end
            end else if (dec && !inc) begin
                if (cnt_q[w] == '0) begin
                    udf_d = 1'b1;
                end else begin
                    cnt_d[w] = cnt_q[w] - PEND_BITS'(1);
                end
            end
        end
    end

    // Counter array and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < PER_ISSUE_WARPS; w++) begin
                cnt_q[w] <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < PER_ISSUE_WARPS; w++) begin
                cnt_q[w] <= cnt_d[w];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Drain status decoded from the registered counters.
    always_comb begin
        pending_empty = '0;
        for (int unsigned w = 0; w < PER_ISSUE_WARPS; w++) begin
            pending_empty[w] = (cnt_q[w] == '0);
        end
    end

    assign err_flags = {udf_q, ovf_q};

endmodule
